// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, shared-response and DRAM-controller signals for mem_port_arbiter.
// Latency: none, wiring only.
// Backpressure: level requests held until a one-cycle reqN_ready pulse; mem_ready closes each DRAM access.
interface mem_port_arbiter_if #(
  parameter int TAG_W   = 18,
  parameter int INDEX_W = 8,
  parameter int DATA_W  = 512
);
  // requester 0
  logic               req0_read;
  logic               req0_write;
  logic [TAG_W-1:0]   req0_tag;
  logic [INDEX_W-1:0] req0_index;
  logic [TAG_W-1:0]   req0_write_tag;
  logic [DATA_W-1:0]  req0_wdata;
  logic               req0_ready;
  // requester 1
  logic               req1_read;
  logic               req1_write;
  logic [TAG_W-1:0]   req1_tag;
  logic [INDEX_W-1:0] req1_index;
  logic [TAG_W-1:0]   req1_write_tag;
  logic [DATA_W-1:0]  req1_wdata;
  logic               req1_ready;
  // shared response / status
  logic [DATA_W-1:0]  rdata;
  logic               err;
  logic               busy;
  // DRAM controller side
  logic               mem_read;
  logic               mem_write;
  logic [TAG_W-1:0]   mem_tag;
  logic [INDEX_W-1:0] mem_index;
  logic [TAG_W-1:0]   mem_write_tag;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_ready;

  // arbiter view: masters the DRAM port, serves both requesters
  modport master (
    input  req0_read, req0_write, req0_tag, req0_index, req0_write_tag, req0_wdata,
    input  req1_read, req1_write, req1_tag, req1_index, req1_write_tag, req1_wdata,
    input  mem_rdata, mem_ready,
    output req0_ready, req1_ready, rdata, err, busy,
    output mem_read, mem_write, mem_tag, mem_index, mem_write_tag, mem_wdata
  );

  // environment view: requesters plus DRAM controller
  modport slave (
    output req0_read, req0_write, req0_tag, req0_index, req0_write_tag, req0_wdata,
    output req1_read, req1_write, req1_tag, req1_index, req1_write_tag, req1_wdata,
    output mem_rdata, mem_ready,
    input  req0_ready, req1_ready, rdata, err, busy,
    input  mem_read, mem_write, mem_tag, mem_index, mem_write_tag, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter onto a single DRAM controller port (IDLE -> BUSY -> RELEASE).
// Latency: grant in cycle 0, mem_* in cycle 1, reqN_ready one cycle after mem_ready.
// Backpressure: one transaction at a time; busy high until RELEASE ends. Watchdog: define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TAG_W   = 18,
  parameter int INDEX_W = 8,
  parameter int DATA_W  = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t             state;
  state_t             next_state;

  logic               pend0;
  logic               pend1;
  logic               grant;
  logic               win;         // winning port of this cycle's grant
  logic               done;        // normal completion this cycle
  logic               abort;       // watchdog completion this cycle
  logic               timeout_hit;

  logic               last;        // port granted most recently
  logic               owner;
  logic               op_write;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [TAG_W-1:0]   write_tag_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               ready0_q;
  logic               ready1_q;

  assign pend0 = bus.req0_read | bus.req0_write;
  assign pend1 = bus.req1_read | bus.req1_write;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state, grant decision and completion detection
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    win        = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 | pend1) begin
          grant      = 1'b1;
          // on a tie the port not served last goes first
          win        = (pend0 & pend1) ? ~last : pend1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        // mem_ready wins over a watchdog expiry in the same cycle
        if (bus.mem_ready) begin
          done       = 1'b1;
          next_state = RELEASE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the winner's request, capture read data, and pulse the owner's ready
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last        <= 1'b1;
      owner       <= 1'b0;
      op_write    <= 1'b0;
      tag_q       <= '0;
      index_q     <= '0;
      write_tag_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
    end else begin
      ready0_q <= (done | abort) & ~owner;
      ready1_q <= (done | abort) & owner;
      if (grant) begin
        last        <= win;
        owner       <= win;
        // read+write together is treated as a write
        op_write    <= win ? bus.req1_write     : bus.req0_write;
        tag_q       <= win ? bus.req1_tag       : bus.req0_tag;
        index_q     <= win ? bus.req1_index     : bus.req0_index;
        write_tag_q <= win ? bus.req1_write_tag : bus.req0_write_tag;
        wdata_q     <= win ? bus.req1_wdata     : bus.req0_wdata;
      end
      if (done && !op_write) rdata_q <= bus.mem_rdata;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // BUSY cycle counter, restarted at every grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (grant)              cnt <= '0;
      else if (state == BUSY) cnt <= cnt + 1'b1;
    end
  end

  // the counter reads TIMEOUT-1 during the TIMEOUT-th BUSY cycle
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign bus.err     = err_q;
`else
  // TIMEOUT only matters to the watchdog build
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus.err        = 1'b0;
`endif

  assign bus.busy          = (state != IDLE);
  assign bus.mem_read      = (state == BUSY) & ~op_write;
  assign bus.mem_write     = (state == BUSY) & op_write;
  assign bus.mem_tag       = tag_q;
  assign bus.mem_index     = index_q;
  assign bus.mem_write_tag = write_tag_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.rdata         = rdata_q;
  assign bus.req0_ready    = ready0_q;
  assign bus.req1_ready    = ready1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, read latency, round-robin ties, read+write, stray and
// reset-aborted completions, and the watchdog when ARB_TIMEOUT_EN is defined.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_mem_port_arbiter;
  localparam int TAG_W   = 18;
  localparam int INDEX_W = 8;
  localparam int DATA_W  = 512;
  localparam int TIMEOUT = 16;

  localparam logic [DATA_W-1:0] D1   = {8{64'h0123_4567_89AB_5632}};
  localparam logic [DATA_W-1:0] D2   = {8{64'hDEAD_BEEF_0000_0002}};
  localparam logic [DATA_W-1:0] D3   = {8{64'h3333_4444_5555_6666}};
  localparam logic [DATA_W-1:0] W1   = {8{64'h1111_2222_1111_2222}};
  localparam logic [DATA_W-1:0] W2   = {8{64'h7777_8888_9999_AAAA}};
  localparam logic [DATA_W-1:0] WA5  = {64{8'hA5}};
  localparam logic [DATA_W-1:0] JUNK = {16{32'hBAD0_BAD0}};

  logic clk;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;
  int   r0_pulses = 0;
  int   r1_pulses = 0;
  int   both_hi = 0;

  mem_port_arbiter_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.req0_ready === 1'b1) r0_pulses++;
    if (bus.req1_ready === 1'b1) r1_pulses++;
    if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both_hi++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_r0;
    int exp_r1;
    rstn = 1'b0;
    bus.req0_read = 1'b0; bus.req0_write = 1'b0; bus.req0_tag = '0; bus.req0_index = '0;
    bus.req0_write_tag = '0; bus.req0_wdata = '0;
    bus.req1_read = 1'b0; bus.req1_write = 1'b0; bus.req1_tag = '0; bus.req1_index = '0;
    bus.req1_write_tag = '0; bus.req1_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;

    // ---- reset state
    step(); step();
    rstn = 1'b1;
    step();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_mem_read", bus.mem_read, 1'b0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    chk1("rst_ready0", bus.req0_ready, 1'b0);
    chk1("rst_ready1", bus.req1_ready, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chkw("rst_rdata", bus.rdata, '0);
    chkw("rst_mem_tag", DATA_W'(bus.mem_tag), '0);

    // ---- single read from port 0, mem_ready 10 cycles after mem_read
    bus.req0_read = 1'b1; bus.req0_index = 8'h05; bus.req0_tag = 18'h1_2345; bus.req0_write_tag = 18'h0_0777;
    step();
    chk1("rd_mem_read", bus.mem_read, 1'b1);
    chk1("rd_mem_write", bus.mem_write, 1'b0);
    chkw("rd_mem_index", DATA_W'(bus.mem_index), DATA_W'(8'h05));
    chkw("rd_mem_tag", DATA_W'(bus.mem_tag), DATA_W'(18'h1_2345));
    chk1("rd_busy", bus.busy, 1'b1);
    repeat (9) step();
    chk1("rd_wait_mem_read", bus.mem_read, 1'b1);
    chk1("rd_wait_ready0", bus.req0_ready, 1'b0);
    bus.mem_ready = 1'b1; bus.mem_rdata = D1;
    step();
    bus.mem_ready = 1'b0; bus.mem_rdata = JUNK;
    chk1("rd_ready0", bus.req0_ready, 1'b1);
    chk1("rd_ready1", bus.req1_ready, 1'b0);
    chk1("rd_err", bus.err, 1'b0);
    chkw("rd_rdata", bus.rdata, D1);
    chk1("rd_mem_read_drop", bus.mem_read, 1'b0);
    chk1("rd_release_busy", bus.busy, 1'b1);
    bus.req0_read = 1'b0;
    step();
    chk1("rd_ready0_one_cycle", bus.req0_ready, 1'b0);
    chk1("rd_idle_busy", bus.busy, 1'b0);

    // ---- stray mem_ready while idle
    bus.mem_ready = 1'b1; bus.mem_rdata = JUNK;
    step();
    bus.mem_ready = 1'b0;
    chk1("stray_ready0", bus.req0_ready, 1'b0);
    chk1("stray_ready1", bus.req1_ready, 1'b0);
    chkw("stray_rdata", bus.rdata, D1);
    chk1("stray_busy", bus.busy, 1'b0);
    step();

    // ---- reset three cycles into BUSY, then a late mem_ready
    bus.req0_read = 1'b1; bus.req0_index = 8'h22;
    step();
    chk1("rb_busy", bus.busy, 1'b1);
    step(); step(); step();
    rstn = 1'b0; bus.req0_read = 1'b0;
    #1;
    chk1("rb_mem_read", bus.mem_read, 1'b0);
    chk1("rb_busy_clr", bus.busy, 1'b0);
    chkw("rb_rdata", bus.rdata, '0);
    chkw("rb_mem_index", DATA_W'(bus.mem_index), '0);
    chkw("rb_mem_tag", DATA_W'(bus.mem_tag), '0);
    step();
    rstn = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = JUNK;
    step();
    bus.mem_ready = 1'b0;
    chk1("rb_late_ready0", bus.req0_ready, 1'b0);
    chk1("rb_late_busy", bus.busy, 1'b0);
    chkw("rb_late_rdata", bus.rdata, '0);
    step();

    // ---- tie after reset: port 0 first, then port 1, then port 0 again
    bus.req0_read = 1'b1; bus.req0_index = 8'h01;
    bus.req1_write = 1'b1; bus.req1_index = 8'h02; bus.req1_wdata = W1;
    step();
    chk1("tie1_mem_read", bus.mem_read, 1'b1);
    chkw("tie1_mem_index", DATA_W'(bus.mem_index), DATA_W'(8'h01));
    bus.mem_ready = 1'b1; bus.mem_rdata = D2;
    step();
    bus.mem_ready = 1'b0;
    chk1("tie1_ready0", bus.req0_ready, 1'b1);
    chk1("tie1_ready1", bus.req1_ready, 1'b0);
    chkw("tie1_rdata", bus.rdata, D2);
    bus.req0_read = 1'b0;
    step();
    chk1("tie1_idle_busy", bus.busy, 1'b0);
    step();
    chk1("tie1b_mem_write", bus.mem_write, 1'b1);
    chk1("tie1b_mem_read", bus.mem_read, 1'b0);
    chkw("tie1b_mem_index", DATA_W'(bus.mem_index), DATA_W'(8'h02));
    chkw("tie1b_mem_wdata", bus.mem_wdata, W1);
    bus.mem_ready = 1'b1; bus.mem_rdata = JUNK;
    step();
    bus.mem_ready = 1'b0;
    chk1("tie1b_ready1", bus.req1_ready, 1'b1);
    chk1("tie1b_ready0", bus.req0_ready, 1'b0);
    chkw("tie1b_rdata_kept", bus.rdata, D2);
    bus.req1_write = 1'b0;
    step();
    bus.req0_write = 1'b1; bus.req0_index = 8'h03; bus.req0_wdata = W2;
    bus.req1_read = 1'b1; bus.req1_index = 8'h04;
    step();
    chk1("tie2_mem_write", bus.mem_write, 1'b1);
    chkw("tie2_mem_index", DATA_W'(bus.mem_index), DATA_W'(8'h03));
    chkw("tie2_mem_wdata", bus.mem_wdata, W2);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk1("tie2_ready0", bus.req0_ready, 1'b1);
    bus.req0_write = 1'b0;
    step(); step();
    chk1("tie2b_mem_read", bus.mem_read, 1'b1);
    chkw("tie2b_mem_index", DATA_W'(bus.mem_index), DATA_W'(8'h04));
    bus.mem_ready = 1'b1; bus.mem_rdata = D3;
    step();
    bus.mem_ready = 1'b0;
    chk1("tie2b_ready1", bus.req1_ready, 1'b1);
    chkw("tie2b_rdata", bus.rdata, D3);
    bus.req1_read = 1'b0;
    step();

    // ---- read+write together from port 1 becomes a write
    bus.req1_read = 1'b1; bus.req1_write = 1'b1; bus.req1_wdata = WA5; bus.req1_index = 8'h33;
    step();
    chk1("rw_mem_write", bus.mem_write, 1'b1);
    chk1("rw_mem_read", bus.mem_read, 1'b0);
    chkw("rw_mem_wdata", bus.mem_wdata, WA5);
    bus.mem_ready = 1'b1; bus.mem_rdata = JUNK;
    step();
    bus.mem_ready = 1'b0;
    chk1("rw_ready1", bus.req1_ready, 1'b1);
    chkw("rw_rdata_kept", bus.rdata, D3);
    bus.req1_read = 1'b0; bus.req1_write = 1'b0;
    step();

    exp_r0 = 3;
    exp_r1 = 3;

`ifdef ARB_TIMEOUT_EN
    // ---- watchdog: no mem_ready, abort after 16 BUSY cycles
    bus.req0_read = 1'b1;
    step();
    repeat (15) step();
    chk1("to_still_busy", bus.mem_read, 1'b1);
    chk1("to_no_ready_yet", bus.req0_ready, 1'b0);
    step();
    chk1("to_ready0", bus.req0_ready, 1'b1);
    chk1("to_err", bus.err, 1'b1);
    chkw("to_rdata_kept", bus.rdata, D3);
    chk1("to_mem_read_drop", bus.mem_read, 1'b0);
    bus.req0_read = 1'b0;
    step();
    chk1("to_idle_busy", bus.busy, 1'b0);
    chk1("to_err_clr", bus.err, 1'b0);
    bus.req1_read = 1'b1;
    step();
    chk1("to_next_mem_read", bus.mem_read, 1'b1);
    bus.mem_ready = 1'b1; bus.mem_rdata = D1;
    step();
    bus.mem_ready = 1'b0;
    chk1("to_next_ready1", bus.req1_ready, 1'b1);
    chk1("to_next_err", bus.err, 1'b0);
    chkw("to_next_rdata", bus.rdata, D1);
    bus.req1_read = 1'b0;
    step();
    exp_r0 = exp_r0 + 1;
    exp_r1 = exp_r1 + 1;
`endif

    step();
    chki("pulses_ready0", r0_pulses, exp_r0);
    chki("pulses_ready1", r1_pulses, exp_r1);
    chki("both_ready_high", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
